// File: rtl/i2s_rx_multi.sv
// I2S / left-justified stereo receiver in the bit-clock domain.
// Truncates or zero-fills slots to WIDTH and flags framing errors.
module i2s_rx_multi #(
  parameter int WIDTH    = 16,
  parameter int MAX_SLOT = 32
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  input  logic             ws_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] leftChan_o,
  output logic [WIDTH-1:0] rightChan_o,
  output logic             pktI2SRxChanged_o,
  output logic             frameErr_o
);

  localparam int CW = $clog2(MAX_SLOT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t MAX_C   = cnt_t'(MAX_SLOT);
  localparam cnt_t WIDTH_C = cnt_t'(WIDTH);

  logic             wsPrev_q, wsPrev2_q, modePrev_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  cnt_t             bitCnt_q, bitCnt_d;
  cnt_t             lastLen_q, lastLen_d;
  logic             synced_q, synced_d;
  logic             leftValid_q, leftValid_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;

  logic modeChg, curCh, slotStart, lenOk;

  assign modeChg   = mode_i != modePrev_q;
  assign curCh     = mode_i ? ws_i : wsPrev_q;
  assign slotStart = mode_i ? (ws_i != wsPrev_q)
                            : (wsPrev_q != wsPrev2_q);
  assign lenOk     = (bitCnt_q >= cnt_t'(2))
                  && (bitCnt_q < MAX_C)
                  && ((lastLen_q == '0)
                   || (bitCnt_q == lastLen_q));

  always_comb begin
    shreg_d     = shreg_q;
    bitCnt_d    = bitCnt_q;
    lastLen_d   = lastLen_q;
    synced_d    = synced_q;
    leftValid_d = leftValid_q;
    left_d      = left_q;
    right_d     = right_q;
    strobe_d    = 1'b0;
    err_d       = 1'b0;

    if (slotStart) begin
      shreg_d  = {sdata_i, {(WIDTH-1){1'b0}}};
      bitCnt_d = cnt_t'(1);
    end else begin
      if (bitCnt_q < WIDTH_C) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (bitCnt_q == cnt_t'(WIDTH-1-i)) shreg_d[i] = sdata_i;
        end
      end
      if (bitCnt_q != MAX_C) bitCnt_d = bitCnt_q + cnt_t'(1);
    end

    // The channel that just ended is the opposite of the new MSB's.
    if (modeChg) begin
      synced_d    = 1'b0;
      leftValid_d = 1'b0;
      lastLen_d   = '0;
    end else if (slotStart) begin
      if (!synced_q) begin
        synced_d = 1'b1;
      end else if (lenOk) begin
        lastLen_d = bitCnt_q;
        if (curCh) begin
          left_d      = shreg_q;
          leftValid_d = 1'b1;
        end else begin
          right_d     = shreg_q;
          strobe_d    = leftValid_q;
          leftValid_d = 1'b0;
        end
      end else begin
        err_d       = 1'b1;
        leftValid_d = 1'b0;
        lastLen_d   = '0;
      end
    end else if (synced_q && bitCnt_q == MAX_C - cnt_t'(1)) begin
      err_d       = 1'b1;
      synced_d    = 1'b0;
      leftValid_d = 1'b0;
      lastLen_d   = '0;
    end
  end

  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      wsPrev_q    <= 1'b0;
      wsPrev2_q   <= 1'b0;
      modePrev_q  <= 1'b0;
      shreg_q     <= '0;
      bitCnt_q    <= '0;
      lastLen_q   <= '0;
      synced_q    <= 1'b0;
      leftValid_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wsPrev_q    <= ws_i;
      wsPrev2_q   <= wsPrev_q;
      modePrev_q  <= mode_i;
      shreg_q     <= shreg_d;
      bitCnt_q    <= bitCnt_d;
      lastLen_q   <= lastLen_d;
      synced_q    <= synced_d;
      leftValid_q <= leftValid_d;
      left_q      <= left_d;
      right_q     <= right_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
    end
  end

  assign leftChan_o        = left_q;
  assign rightChan_o       = right_q;
  assign pktI2SRxChanged_o = strobe_q;
  assign frameErr_o        = err_q;

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Directed bench for i2s_rx_multi: framing modes, slot sizes,
// length/stuck-WS errors, mode change and async reset.
module tb_i2s_rx_multi;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic mode = 1'b0;
  logic ws   = 1'b0;
  logic sd   = 1'b0;

  logic [15:0] l, r, lw, rw;
  logic        stb, err, stbw, errw;

  i2s_rx_multi dut (
    .sclk_i(sclk), .rst_i(rst), .mode_i(mode),
    .ws_i(ws), .sdata_i(sd),
    .leftChan_o(l), .rightChan_o(r),
    .pktI2SRxChanged_o(stb), .frameErr_o(err)
  );

  i2s_rx_multi #(.WIDTH(16), .MAX_SLOT(48)) dut_w (
    .sclk_i(sclk), .rst_i(rst), .mode_i(mode),
    .ws_i(ws), .sdata_i(sd),
    .leftChan_o(lw), .rightChan_o(rw),
    .pktI2SRxChanged_o(stbw), .frameErr_o(errw)
  );

  always #5 sclk = ~sclk;

  int nvec = 0;
  int nmis = 0;
  int edgeN;
  int stbQ[$];
  int errQ[$];
  int dbl;
  logic pS, pE;
  logic prevBit;
  logic wideSel;
  logic [15:0] errL, errR;

  typedef struct {
    logic        m;
    logic        wide;
    int          len;
    logic [31:0] dl;
    logic [31:0] dr;
    int          frames;
    logic [15:0] el;
    logic [15:0] er;
    int          nstb;
    int          first;
  } vec_t;

  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [15:0] curL();
    return wideSel ? lw : l;
  endfunction

  function automatic logic [15:0] curR();
    return wideSel ? rw : r;
  endfunction

  task automatic clr();
    edgeN = 0;
    stbQ.delete();
    errQ.delete();
    dbl = 0;
    pS = 1'b0;
    pE = 1'b0;
  endtask

  // b is the bit aligned with WS; I2S puts it on the line one clock later.
  task automatic tick(input logic w, input logic b);
    logic s, e;
    ws = w;
    sd = mode ? b : prevBit;
    prevBit = b;
    @(posedge sclk);
    #1;
    edgeN++;
    s = wideSel ? stbw : stb;
    e = wideSel ? errw : err;
    if (s) stbQ.push_back(edgeN);
    if (e) begin
      errQ.push_back(edgeN);
      errL = curL();
      errR = curR();
    end
    if ((s && pS) || (e && pE)) dbl++;
    pS = s;
    pE = e;
  endtask

  task automatic send(input logic w, input logic [31:0] d,
                      input int len, input int from, input int to);
    for (int b = from; b < to; b++) tick(w, d[len-1-b]);
  endtask

  task automatic slot(input logic w, input logic [31:0] d, input int len);
    send(w, d, len, 0, len);
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mode = m;
    ws = 1'b0;
    sd = 1'b0;
    prevBit = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    chk("rst_left", 32'(curL()), 32'h0);
    chk("rst_right", 32'(curR()), 32'h0);
    chk("rst_flags", {30'h0, stb, err}, 32'h0);
    rst = 1'b1;
    clr();
  endtask

  initial begin
    errL = '0;
    errR = '0;
    wideSel = 1'b0;
    clr();

    v[0] = '{1'b0, 1'b0, 16, 32'h1234, 32'hABCD, 3,
             16'h1234, 16'hABCD, 2, 66};
    v[1] = '{1'b1, 1'b0, 16, 32'h1234, 32'hABCD, 3,
             16'h1234, 16'hABCD, 2, 65};
    v[2] = '{1'b0, 1'b1, 32, 32'h89ABCDEF, 32'h01234567, 3,
             16'h89AB, 16'h0123, 2, 130};
    v[3] = '{1'b1, 1'b0, 12, 32'hABC, 32'h123, 3,
             16'hABC0, 16'h1230, 2, 49};
    v[4] = '{1'b0, 1'b0, 24, 32'hFEDCBA, 32'h13579B, 3,
             16'hFEDC, 16'h1357, 2, 98};

    foreach (v[k]) begin
      wideSel = v[k].wide;
      do_reset(v[k].m);
      for (int f = 0; f < v[k].frames; f++) begin
        slot(1'b0, v[k].dl, v[k].len);
        slot(1'b1, v[k].dr, v[k].len);
      end
      repeat (2) tick(1'b0, 1'b0);
      chk($sformatf("v%0d_left", k), 32'(curL()), 32'(v[k].el));
      chk($sformatf("v%0d_right", k), 32'(curR()), 32'(v[k].er));
      chk($sformatf("v%0d_nstb", k), stbQ.size(), v[k].nstb);
      chk($sformatf("v%0d_first", k), at(stbQ, 0), v[k].first);
      chk($sformatf("v%0d_nerr", k), errQ.size(), 0);
      chk($sformatf("v%0d_dbl", k), dbl, 0);
    end
    wideSel = 1'b0;

    // Short right slot in LJ mode
    do_reset(1'b1);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h5555, 16);
    send(1'b1, 32'h6666, 16, 0, 15);
    slot(1'b0, 32'h0F0F, 16);
    slot(1'b1, 32'hF0F0, 16);
    repeat (2) tick(1'b0, 1'b0);
    chk("short_nerr", errQ.size(), 1);
    chk("short_erredge", at(errQ, 0), 96);
    chk("short_err_right", 32'(errR), 32'hABCD);
    chk("short_err_left", 32'(errL), 32'h5555);
    chk("short_nstb", stbQ.size(), 2);
    chk("short_stb0", at(stbQ, 0), 65);
    chk("short_stb1", at(stbQ, 1), 128);
    chk("short_left", 32'(l), 32'h0F0F);
    chk("short_right", 32'(r), 32'hF0F0);

    // Stuck WS in I2S mode
    do_reset(1'b0);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    repeat (40) tick(1'b0, 1'b0);
    slot(1'b1, 32'h1111, 16);
    slot(1'b0, 32'h0BAD, 16);
    slot(1'b1, 32'hF00D, 16);
    slot(1'b0, 32'h0BAD, 16);
    slot(1'b1, 32'hF00D, 16);
    repeat (2) tick(1'b0, 1'b0);
    chk("stuck_nerr", errQ.size(), 1);
    chk("stuck_erredge", at(errQ, 0), 97);
    chk("stuck_nstb", stbQ.size(), 3);
    chk("stuck_stb1", at(stbQ, 1), 154);
    chk("stuck_left", 32'(l), 32'h0BAD);
    chk("stuck_right", 32'(r), 32'hF00D);
    chk("stuck_dbl", dbl, 0);

    // Asynchronous reset in the middle of a right slot
    do_reset(1'b0);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h4321, 16);
    send(1'b1, 32'hABCD, 16, 0, 8);
    chk("arst_pre_left", 32'(l), 32'h4321);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_left", 32'(l), 32'h0);
    chk("arst_right", 32'(r), 32'h0);
    chk("arst_flags", {30'h0, stb, err}, 32'h0);
    send(1'b1, 32'hABCD, 16, 8, 16);
    send(1'b0, 32'h0F0F, 16, 0, 4);
    rst = 1'b1;
    clr();
    send(1'b0, 32'h0F0F, 16, 4, 16);
    slot(1'b1, 32'hF0F0, 16);
    slot(1'b0, 32'h7777, 16);
    slot(1'b1, 32'h8888, 16);
    repeat (2) tick(1'b0, 1'b0);
    chk("arst_nstb", stbQ.size(), 1);
    chk("arst_stb0", at(stbQ, 0), 62);
    chk("arst_nerr", errQ.size(), 0);
    chk("arst_post_left", 32'(l), 32'h7777);
    chk("arst_post_right", 32'(r), 32'h8888);

    // Mode change LJ -> I2S mid left slot
    do_reset(1'b1);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h1234, 16);
    slot(1'b1, 32'hABCD, 16);
    send(1'b0, 32'h1234, 16, 0, 5);
    mode = 1'b0;
    send(1'b0, 32'h1234, 16, 5, 16);
    slot(1'b1, 32'hABCD, 16);
    slot(1'b0, 32'h2222, 16);
    slot(1'b1, 32'h3333, 16);
    repeat (2) tick(1'b0, 1'b0);
    chk("mchg_nerr", errQ.size(), 0);
    chk("mchg_nstb", stbQ.size(), 2);
    chk("mchg_stb1", at(stbQ, 1), 130);
    chk("mchg_left", 32'(l), 32'h2222);
    chk("mchg_right", 32'(r), 32'h3333);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
